// File: rtl/nibble_packer_4in_pkg.sv
// nibble_packer_4in_pkg: shared widths and state encoding for the nibble packer.
package nibble_packer_4in_pkg;
  localparam int NIB_W = 4;
  localparam int NIB_CNT = 4;
  localparam int WORD_W = 16;
  localparam int CNT_W = $clog2(NIB_CNT);
  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;
endpackage

// File: rtl/nibble_packer_4in_if.sv
// nibble_packer_4in_if: nibble-in / word-out handshake bundle; FLUSH exists only with PACKER_FLUSH_EN.
interface nibble_packer_4in_if;
  import nibble_packer_4in_pkg::*;
  logic [NIB_W-1:0] NIB_IN;
  logic NIB_VALID;
  logic NIB_READY;
  logic [WORD_W-1:0] NIBBLES;
  logic NIBBLES_VALID;
  logic NIBBLES_READY;
  logic [7:0] WORD_CNT;
`ifdef PACKER_FLUSH_EN
  logic FLUSH;
  modport master (output NIB_IN, NIB_VALID, NIBBLES_READY, FLUSH,
                  input NIB_READY, NIBBLES, NIBBLES_VALID, WORD_CNT);
  modport slave (input NIB_IN, NIB_VALID, NIBBLES_READY, FLUSH,
                 output NIB_READY, NIBBLES, NIBBLES_VALID, WORD_CNT);
`else
  modport master (output NIB_IN, NIB_VALID, NIBBLES_READY,
                  input NIB_READY, NIBBLES, NIBBLES_VALID, WORD_CNT);
  modport slave (input NIB_IN, NIB_VALID, NIBBLES_READY,
                 output NIB_READY, NIBBLES, NIBBLES_VALID, WORD_CNT);
`endif
endinterface

// File: rtl/nibble_slot_counter.sv
// nibble_slot_counter: 2-bit slot index with clear, load-1 and increment (priority in that order).
module nibble_slot_counter
  import nibble_packer_4in_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             clr,
  input  logic             ld1,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge CLK or negedge RESET_L)
    if (!RESET_L) cnt <= '0;
    else cnt <= clr ? '0 : ld1 ? CNT_W'(1) : inc ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/nibble_packer_4in.sv
// nibble_packer_4in: packs four serial nibbles into a 16-bit word, LSB slot first.
// Optional PACKER_FLUSH_EN adds FLUSH to emit a partial word padded with PAD_NIBBLE.
module nibble_packer_4in
  import nibble_packer_4in_pkg::*;
#(
  parameter logic [NIB_W-1:0] PAD_NIBBLE = 4'h0
) (
  input logic                CLK,
  input logic                RESET_L,
  nibble_packer_4in_if.slave bus
);
  localparam logic [WORD_W-1:0] PAD_WORD = {NIB_CNT{PAD_NIBBLE}};
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WORD_W-1:0] part_q, pack, word_q;
  logic [7:0] word_cnt_q;
  logic acc, hs, emit, flush_ok;
`ifdef PACKER_FLUSH_EN
  assign flush_ok = bus.FLUSH && cnt != '0;
`else
  assign flush_ok = 1'b0;
`endif
  assign bus.NIBBLES_VALID = state == FULL;
  assign bus.NIB_READY = ~bus.NIBBLES_VALID | bus.NIBBLES_READY;
  assign bus.NIBBLES = word_q;
  assign bus.WORD_CNT = word_cnt_q;
  // part_q starts pre-padded so a flushed partial word needs no extra fill logic
  always_comb begin
    acc = bus.NIB_VALID & bus.NIB_READY;
    hs = bus.NIBBLES_VALID & bus.NIBBLES_READY;
    pack = part_q;
    if (acc) pack[{cnt, 2'b00} +: NIB_W] = bus.NIB_IN;
    emit = state == COLLECT && ((acc && cnt == CNT_W'(NIB_CNT - 1)) || flush_ok);
    state_nxt = emit ? FULL : hs ? COLLECT : state;
  end
  always_ff @(posedge CLK or negedge RESET_L)
    if (!RESET_L) state <= COLLECT;
    else state <= state_nxt;
  always_ff @(posedge CLK or negedge RESET_L)
    if (!RESET_L) begin
      part_q <= PAD_WORD;
      word_q <= '0;
      word_cnt_q <= '0;
    end else begin
      part_q <= emit ? PAD_WORD : pack;
      word_q <= emit ? pack : word_q;
      word_cnt_q <= word_cnt_q + 8'(hs);
    end
  nibble_slot_counter u_cnt (
    .CLK    (CLK),
    .RESET_L(RESET_L),
    .clr    (emit | (hs & ~acc)),
    .ld1    (hs & acc),
    .inc    (acc),
    .cnt    (cnt)
  );
endmodule
